// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester, read-return and RAM-side signals shared by the two-port RAM arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;
    logic              p0_req,    p1_req;
    logic [ADDR_W-1:0] p0_addr,   p1_addr;
    logic [DATA_W-1:0] p0_wdata,  p1_wdata;
    logic [BE_W-1:0]   p0_wren,   p1_wren;
    logic              p0_lock,   p1_lock;
    logic              p0_gnt,    p1_gnt;
    logic              p0_rvalid, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata,  p1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BE_W-1:0]   ram_wren;
    logic              ram_cs;
    logic [DATA_W-1:0] ram_rdata;
    logic              lock_err;
    modport master (
        output p0_req, p1_req, p0_addr, p1_addr, p0_wdata, p1_wdata,
               p0_wren, p1_wren, p0_lock, p1_lock, ram_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
               ram_addr, ram_wdata, ram_wren, ram_cs, lock_err
    );
    modport slave (
        input  p0_req, p1_req, p0_addr, p1_addr, p0_wdata, p1_wdata,
               p0_wren, p1_wren, p0_lock, p1_lock, ram_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
               ram_addr, ram_wdata, ram_wren, ram_cs, lock_err
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port fair arbiter with bounded locking in front of a single-port RAM.
module ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ram_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t           r_state, w_next;
    logic             r_last, w_last_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rvalid;
    logic [1:0]       w_req, w_lock, w_gnt, w_rd;
    logic             w_force;
    assign w_req  = {bus.p1_req, bus.p0_req};
    assign w_lock = {bus.p1_lock, bus.p0_lock};
    assign w_rd   = {bus.p1_wren == '0, bus.p0_wren == '0};
    always_comb begin
        w_gnt       = 2'b00;
        w_next      = r_state;
        w_last_next = r_last;
        w_force     = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt  = (&w_req) ? (r_last ? 2'b01 : 2'b10) : w_req;
                w_next = (w_gnt[0] && w_lock[0]) ? OWN0 : (w_gnt[1] && w_lock[1]) ? OWN1 : IDLE;
            end
            OWN0: begin
                w_gnt   = {1'b0, w_req[0]};
                w_force = r_cnt == CNT_W'(LOCK_MAX);
                w_next  = (w_force || !w_lock[0]) ? IDLE : OWN0;
            end
            OWN1: begin
                w_gnt   = {w_req[1], 1'b0};
                w_force = r_cnt == CNT_W'(LOCK_MAX);
                w_next  = (w_force || !w_lock[1]) ? IDLE : OWN1;
            end
            default: w_next = IDLE;
        endcase
        // Requests are ignored while reset is held so the RAM sees nothing.
        if (i_rst) w_gnt = 2'b00;
        w_last_next = w_gnt[0] ? 1'b0 : w_gnt[1] ? 1'b1 : w_last_next;
        // A forced release hands the next contention to the other port.
        if (w_force) w_last_next = r_state == OWN1;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_rvalid <= 2'b00;
        end else begin
            r_state  <= w_next;
            r_last   <= w_last_next;
            r_cnt    <= (r_state == IDLE) ? '0 : (r_cnt == CNT_W'(LOCK_MAX)) ? r_cnt : r_cnt + 1'b1;
            r_rvalid <= w_gnt & w_rd;
        end
    end
    assign bus.p0_gnt    = w_gnt[0];
    assign bus.p1_gnt    = w_gnt[1];
    assign bus.ram_cs    = |w_gnt;
    assign bus.ram_addr  = w_gnt[0] ? bus.p0_addr  : w_gnt[1] ? bus.p1_addr  : '0;
    assign bus.ram_wdata = w_gnt[0] ? bus.p0_wdata : w_gnt[1] ? bus.p1_wdata : '0;
    assign bus.ram_wren  = w_gnt[0] ? bus.p0_wren  : w_gnt[1] ? bus.p1_wren  : '0;
    assign bus.lock_err  = w_force;
    assign bus.p0_rvalid = r_rvalid[0];
    assign bus.p1_rvalid = r_rvalid[1];
    assign bus.p0_rdata  = r_rvalid[0] ? bus.ram_rdata : '0;
    assign bus.p1_rdata  = r_rvalid[1] ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_ram_arbiter;
    localparam int AW = 12, DW = 32, BW = 4, LM = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
    logic          req [2];
    logic          lock [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [BW-1:0] wren [2];
    assign bus.p0_req = req[0];     assign bus.p1_req = req[1];
    assign bus.p0_lock = lock[0];   assign bus.p1_lock = lock[1];
    assign bus.p0_addr = addr[0];   assign bus.p1_addr = addr[1];
    assign bus.p0_wdata = wdata[0]; assign bus.p1_wdata = wdata[1];
    assign bus.p0_wren = wren[0];   assign bus.p1_wren = wren[1];
    // RAM with a one-cycle read latency, written only through the arbiter outputs.
    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            for (int b = 0; b < BW; b++)
                if (bus.ram_wren[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end
    int checks = 0, passed = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // Behavioural model: who owns the RAM, who was served last, how long the owner has held it.
    logic [DW-1:0] ref_mem [1<<AW];
    int            owner = -1, own_cycles = 0, pend_p = 0;
    bit            last = 1'b1, pend_v = 1'b0;
    logic [DW-1:0] pend_d = '0;
    logic [1:0]    m_gnt, s_gnt, s_rv;
    logic [DW-1:0] s_rd0, s_rd1;
    logic          s_err, s_cs;
    logic [BW-1:0] s_wren;
    task automatic step();
        int g;
        bit frc;
        logic [1:0] erv;
        @(negedge clk);
        s_gnt = {bus.p1_gnt, bus.p0_gnt};
        s_rv = {bus.p1_rvalid, bus.p0_rvalid};
        s_rd0 = bus.p0_rdata;
        s_rd1 = bus.p1_rdata;
        s_err = bus.lock_err;
        s_cs = bus.ram_cs;
        s_wren = bus.ram_wren;
        g = -1;
        frc = 1'b0;
        if (!rst) begin
            frc = owner >= 0 && own_cycles == LM;
            if (owner >= 0) g = req[owner] ? owner : -1;
            else if (req[0] && req[1]) g = last ? 0 : 1;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end
        m_gnt = (g < 0) ? 2'b00 : (g == 0) ? 2'b01 : 2'b10;
        erv = (!rst && pend_v) ? ((pend_p == 0) ? 2'b01 : 2'b10) : 2'b00;
        chk("gnt", s_gnt, m_gnt);
        chk("rvalid", s_rv, erv);
        chk("rdata0", s_rd0, erv[0] ? pend_d : '0);
        chk("rdata1", s_rd1, erv[1] ? pend_d : '0);
        chk("ram_cs", s_cs, g >= 0);
        chk("ram_addr", bus.ram_addr, (g >= 0) ? addr[g] : '0);
        chk("ram_wdata", bus.ram_wdata, (g >= 0) ? wdata[g] : '0);
        chk("ram_wren", s_wren, (g >= 0) ? wren[g] : '0);
        chk("lock_err", s_err, frc);
        if (rst) begin
            owner = -1; last = 1'b1; own_cycles = 0; pend_v = 1'b0;
        end else begin
            pend_v = 1'b0;
            if (g >= 0) begin
                last = g[0];
                if (wren[g] == '0) begin
                    pend_v = 1'b1; pend_p = g; pend_d = ref_mem[addr[g]];
                end else begin
                    for (int b = 0; b < BW; b++)
                        if (wren[g][b]) ref_mem[addr[g]][8*b +: 8] = wdata[g][8*b +: 8];
                end
            end
            if (owner < 0) begin
                if (g >= 0 && lock[g]) begin owner = g; own_cycles = 0; end
            end else if (frc) begin
                last = owner[0]; owner = -1;
            end else if (!lock[owner]) owner = -1;
            else own_cycles++;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic drive(int n, bit r, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] we, bit l);
        req[n] = r; addr[n] = a; wdata[n] = d; wren[n] = we; lock[n] = l;
    endtask
    bit busy [2];
    int errs, err_idx;
    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram[i] = 32'hC0DE0000 | DW'(i);
            ref_mem[i] = 32'hC0DE0000 | DW'(i);
        end
        bus.ram_rdata = '0;
        drive(0, 1, 12'h010, '0, '0, 0);
        drive(1, 1, 12'h020, '0, '0, 0);
        step();
        step();
        chk("rst_gnt", s_gnt, 2'b00);
        chk("rst_cs", s_cs, 0);
        rst = 1'b0;
        step();
        chk("dual_rd_gnt_c1", s_gnt, 2'b01);
        req[0] = 0;
        step();
        chk("dual_rd_gnt_c2", s_gnt, 2'b10);
        chk("dual_rd_p0_data", s_rd0, 32'hC0DE0010);
        chk("dual_rd_p0_rv", s_rv, 2'b01);
        req[1] = 0;
        step();
        chk("dual_rd_p1_data", s_rd1, 32'hC0DE0020);
        chk("dual_rd_p1_rv", s_rv, 2'b10);
        drive(0, 1, 12'h005, 32'hDEADBEEF, 4'b0011, 0);
        step();
        chk("bw_wren", s_wren, 4'b0011);
        req[0] = 0;
        drive(1, 1, 12'h005, '0, '0, 0);
        step();
        chk("bw_no_p0_rv", s_rv, 2'b00);
        req[1] = 0;
        step();
        chk("bw_rd_data", s_rd1, 32'hC0DEBEEF);
        chk("bw_rd_rv", s_rv, 2'b10);
        drive(1, 1, 12'h001, '0, '0, 1);
        step();
        chk("lk_take", s_gnt, 2'b10);
        drive(0, 1, 12'h002, '0, '0, 0);
        drive(1, 1, 12'h003, '0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lk_hold", s_gnt, 2'b10);
        end
        lock[1] = 0;
        step();
        chk("lk_release", s_gnt, 2'b10);
        req[1] = 0;
        step();
        chk("lk_after", s_gnt, 2'b01);
        req[0] = 0;
        drive(0, 1, 12'h009, '0, '0, 1);
        step();
        chk("to_take", s_gnt, 2'b01);
        drive(1, 1, 12'h00A, '0, '0, 0);
        errs = 0;
        err_idx = -1;
        for (int i = 0; i <= LM; i++) begin
            step();
            chk("to_hold", s_gnt, 2'b01);
            if (s_err) begin errs++; err_idx = i; end
        end
        chk("to_err_count", errs, 1);
        chk("to_err_cycle", err_idx, LM);
        step();
        chk("to_p1_wins", s_gnt, 2'b10);
        chk("to_err_done", s_err, 0);
        drive(0, 0, '0, '0, '0, 0);
        drive(1, 0, '0, '0, '0, 0);
        step();
        drive(0, 1, 12'h007, '0, '0, 0);
        step();
        chk("rr_gnt", s_gnt, 2'b01);
        rst = 1'b1;
        drive(0, 1, 12'h010, '0, '0, 0);
        drive(1, 1, 12'h020, '0, '0, 0);
        step();
        chk("rr_no_rv", s_rv, 2'b00);
        chk("rr_cs", s_cs, 0);
        step();
        rst = 1'b0;
        step();
        chk("rr_p0_first", s_gnt, 2'b01);
        chk("rr_no_rv_after", s_rv, 2'b00);
        req[0] = 0;
        step();
        chk("rr_p1_next", s_gnt, 2'b10);
        req[1] = 0;
        step();
        busy[0] = 0;
        busy[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 399) == 0;
            for (int n = 0; n < 2; n++) begin
                if (!busy[n] && $urandom_range(0, 2) == 0) begin
                    busy[n] = 1;
                    addr[n] = AW'($urandom_range(0, 15));
                    wdata[n] = $urandom;
                    wren[n] = $urandom_range(0, 1) ? '0 : BW'($urandom_range(1, 15));
                    lock[n] = $urandom_range(0, 3) == 0;
                end else if (!busy[n]) lock[n] = $urandom_range(0, 7) == 0;
                req[n] = busy[n];
            end
            step();
            for (int n = 0; n < 2; n++) if (m_gnt[n]) busy[n] = 0;
        end
        rst = 1'b0;
        drive(0, 0, '0, '0, '0, 0);
        drive(1, 0, '0, '0, '0, 0);
        step();
        step();
        for (int i = 0; i < 16; i++) chk("mem", ram[i], ref_mem[i]);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, data width; byte enables are DATA_W/8 bits.
REQ-003 Parameter LOCK_MAX, default 16, maximum consecutive cycles one port holds a lock.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 P0_REQ / P1_REQ  input  1  port n requests one RAM access this cycle.
REQ-007 P0_ADDR / P1_ADDR  input  ADDR_W  word address.
REQ-008 P0_WDATA / P1_WDATA  input  DATA_W  write data.
REQ-009 P0_WREN / P1_WREN  input  DATA_W/8  byte write enables; all-zero means read.
REQ-010 P0_LOCK / P1_LOCK  input  1  keep grant ownership after this access.
REQ-011 P0_GNT / P1_GNT  output  1  access accepted this cycle (combinational from REQ and state).
REQ-012 P0_RVALID / P1_RVALID  output  1  read data valid for port n.
REQ-013 P0_RDATA / P1_RDATA  output  DATA_W  read data for port n.
REQ-014 RAM_ADDR  output  ADDR_W  address to single-port RAM.
REQ-015 RAM_WDATA  output  DATA_W  write data to RAM.
REQ-016 RAM_WREN  output  DATA_W/8  byte enables to RAM.
REQ-017 RAM_CS  output  1  RAM chip select.
REQ-018 RAM_RDATA  input  DATA_W  RAM read data, valid one cycle after a selected read (unregistered RAM output).
REQ-019 LOCK_ERR  output  1  one-cycle pulse when a lock is force-released.

Function
REQ-020 Transfer occurs in a cycle where Pn_REQ and Pn_GNT are both 1; requester holds REQ and command stable until granted.
REQ-021 At most one GNT is 1 per cycle; GNT is never 1 without the matching REQ.
REQ-022 During a transfer, RAM_CS=1 and RAM_ADDR/RAM_WDATA/RAM_WREN equal the granted port's inputs; with no transfer, RAM_CS=0, RAM_WREN=0, RAM_ADDR=0, RAM_WDATA=0.
REQ-023 States: IDLE (no owner), OWN0, OWN1 (port locked).
REQ-024 In IDLE, one requester is granted; if both request, the port not granted most recently (LAST register) is granted.
REQ-025 LAST updates to the granted port index on every transfer.
REQ-026 IDLE->OWNn when port n transfers with Pn_LOCK=1.
REQ-027 In OWNn only port n is granted; the other port waits regardless of REQ.
REQ-028 OWNn->IDLE when port n transfers with Pn_LOCK=0, or when Pn_REQ=0 and Pn_LOCK=0 in the same cycle.
REQ-029 Lock counter clears on entry to OWNn, increments each cycle in OWNn, saturates at LOCK_MAX.
REQ-030 When the counter reaches LOCK_MAX while in OWNn: next state IDLE, LOCK_ERR=1 for one cycle, LAST set to n so the other port wins the next contention; any transfer completed that cycle stands.
REQ-031 Read transfer (WREN=0) by port n: Pn_RVALID=1 exactly one cycle later with Pn_RDATA=RAM_RDATA; the other port's RVALID stays 0.
REQ-032 Write transfers produce no RVALID.
REQ-033 Back-to-back reads, including alternating ports, sustain one access per cycle.
REQ-034 Pn_RDATA is 0 whenever Pn_RVALID=0.

Reset
REQ-035 While RST=1: state IDLE, LAST=1 (port 0 wins first contention), lock counter 0, LOCK_ERR=0, both GNT=0, both RVALID=0, RAM_CS=0, RAM_WREN=0, RAM_ADDR=0, RAM_WDATA=0.
REQ-036 Reset asserted mid-operation discards any pending read return; no RVALID occurs in the cycle after reset is released.

Verification
REQ-037 Both ports request a read at the same time after reset, P0_ADDR=0x010, P1_ADDR=0x020 -> P0_GNT in cycle 1, P1_GNT in cycle 2, each RVALID one cycle after its grant with that address's data.
REQ-038 P0 writes 0xDEADBEEF to 0x005 with WREN=4'b0011, then P1 reads 0x005 -> RAM_WREN=4'b0011 on the write, P1_RDATA shows the low half updated, no P0_RVALID.
REQ-039 P1 transfers with LOCK=1, both then request for 3 cycles -> P1 granted all 3 cycles, P0_GNT=0; P1 LOCK=0 transfer -> P0 granted next cycle.
REQ-040 P0 holds LOCK=1 for LOCK_MAX+2 cycles with P1 requesting -> LOCK_ERR pulses once at LOCK_MAX, P1 granted the following cycle.
REQ-041 RST asserted in the cycle after a granted read -> no RVALID, all RAM outputs 0 while RST=1, P0 wins the first post-reset contention.
REQ-042 Randomised traffic on both ports -> no cycle with two GNTs, every read gets exactly one RVALID on the correct port, and RAM contents match a reference model.
